// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: shared state encoding, funct codes and iteration count for the divide sequencer
package div_sequencer_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;
    localparam logic [5:0] DIV      = 6'b011010;
    localparam logic [5:0] DIVU     = 6'b011011;
    localparam int         DIV_ITER = 32;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-divide iteration on {rem, quo}
module div_step
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_ITER
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_sh;
    logic [WIDTH:0] w_trial;
    logic           w_ge;
    // rem < divisor always holds, so the shifted remainder and the trial both fit in WIDTH+1 bits
    always_comb begin
        w_sh    = {i_rem, i_quo[WIDTH-1]};
        w_trial = w_sh - {1'b0, i_div};
        w_ge    = !w_trial[WIDTH];
        o_rem   = w_ge ? w_trial[WIDTH-1:0] : w_sh[WIDTH-1:0];
        o_quo   = {i_quo[WIDTH-2:0], w_ge};
    end
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIV/DIVU sequencer that stalls E and writes HI/LO on completion
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             annulE,
    output logic             stall_div,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             hilo_we
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_we;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_hi_fin;
    logic [WIDTH-1:0] w_lo_fin;
    logic             w_start;
    logic             w_last;

    assign w_start  = (r_state == IDLE) && startE && !annulE;
    assign w_last   = (r_state == BUSY) && (r_cnt == CW'(WIDTH - 1));
    assign w_abs_a  = (signedE && srcaE[WIDTH-1]) ? -srcaE : srcaE;
    assign w_abs_b  = (signedE && srcbE[WIDTH-1]) ? -srcbE : srcbE;
    assign w_hi_fin = r_rneg ? -w_rem_nxt : w_rem_nxt;
    assign w_lo_fin = r_qneg ? -w_quo_nxt : w_quo_nxt;
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;
    assign hilo_we  = r_we;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // next state and stall; annul always returns to IDLE, DONE and illegal codes fall back to IDLE
    always_comb begin
        w_next    = IDLE;
        stall_div = 1'b0;
        if (annulE)                w_next = IDLE;
        else if (r_state == BUSY)  w_next = w_last ? DONE : BUSY;
        else if (w_start)          w_next = BUSY;
        stall_div = w_start || (r_state == BUSY);
    end

    // operand capture, iteration, and HI/LO result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_we   <= 1'b0;
        end else begin
            r_we <= w_last && !annulE;
            if (w_start) begin
                r_rem  <= '0;
                r_quo  <= w_abs_a;
                r_div  <= w_abs_b;
                r_cnt  <= '0;
                r_qneg <= signedE && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]) && (|srcbE);
                r_rneg <= signedE && srcaE[WIDTH-1];
            end
            if ((r_state == BUSY) && !annulE) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_hi <= w_hi_fin;
                    r_lo <= w_lo_fin;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: scoreboard bench for div_sequencer against an arithmetic reference model
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        startE = 1'b0;
    logic        signedE = 1'b0;
    logic        annulE = 1'b0;
    logic [31:0] srcaE = '0;
    logic [31:0] srcbE = '0;
    logic        stall_div;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        hilo_we;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];

    div_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .startE    (startE),
        .signedE   (signedE),
        .srcaE     (srcaE),
        .srcbE     (srcbE),
        .annulE    (annulE),
        .stall_div (stall_div),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .hilo_we   (hilo_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // MIPS divide semantics: {HI, LO}
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        if (s) return {32'(sa % sb), 32'(sa / sb)};
        return {a % b, a / b};
    endfunction

    // monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (hilo_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got hi=%h lo=%h expected no strobe", hi_o, lo_o);
            end else begin
                check("hilo", {hi_o, lo_o}, exp_q.pop_front());
            end
        end
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
        int n;
        n = 0;
        exp_q.push_back(model(a, b, f == DIV));
        @(posedge clk);
        #1;
        startE  = (f == DIV) || (f == DIVU);
        signedE = (f == DIV);
        srcaE   = a;
        srcbE   = b;
        @(negedge clk);
        while (stall_div && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("stall_len", 64'(n), 64'd33);
        check("strobe_after_stall", 64'(hilo_we), 64'd1);
        @(posedge clk);
        #1;
        startE = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  f;
        int          sel;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", 64'(hi_o), 64'd0);
        check("reset_lo", 64'(lo_o), 64'd0);
        check("reset_we", 64'(hilo_we), 64'd0);
        check("reset_stall", 64'(stall_div), 64'd0);
        rst = 1'b1;

        run_div(32'd100, 32'd7, DIVU);
        check("divu_100_7", {hi_o, lo_o}, {32'd2, 32'd14});
        run_div(32'hFFFF_FFF9, 32'd2, DIV);
        check("div_m7_2", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div(32'd7, 32'hFFFF_FFFE, DIV);
        check("div_7_m2", {hi_o, lo_o}, {32'd1, 32'hFFFF_FFFD});
        run_div(32'h8000_0000, 32'hFFFF_FFFF, DIV);
        check("div_overflow", {hi_o, lo_o}, {32'd0, 32'h8000_0000});
        run_div(32'hFFFF_FFFF, 32'd1, DIVU);
        check("divu_max_1", {hi_o, lo_o}, {32'd0, 32'hFFFF_FFFF});
        run_div(32'd1234, 32'd0, DIVU);
        check("divu_by_zero", {hi_o, lo_o}, {32'd1234, 32'hFFFF_FFFF});
        run_div(32'hFFFF_FF00, 32'd0, DIV);
        check("div_neg_by_zero", {hi_o, lo_o}, {32'hFFFF_FF00, 32'hFFFF_FFFF});

        // annul an in-flight divide
        run_div(32'd100, 32'd7, DIVU);
        @(posedge clk);
        #1;
        startE = 1'b1; signedE = 1'b0; srcaE = 32'd50; srcbE = 32'd5;
        repeat (10) @(posedge clk);
        #1;
        annulE = 1'b1;
        @(posedge clk);
        #1;
        annulE = 1'b0;
        startE = 1'b0;
        @(negedge clk);
        check("annul_stall_low", 64'(stall_div), 64'd0);
        check("annul_hilo_kept", {hi_o, lo_o}, {32'd2, 32'd14});
        repeat (40) @(negedge clk);
        check("annul_hilo_still", {hi_o, lo_o}, {32'd2, 32'd14});
        run_div(32'd50, 32'd5, DIVU);
        check("restart_50_5", {hi_o, lo_o}, {32'd0, 32'd10});

        // reset mid-operation
        @(posedge clk);
        #1;
        startE = 1'b1; signedE = 1'b0; srcaE = 32'd1000; srcbE = 32'd3;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        startE = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_hi", 64'(hi_o), 64'd0);
        check("midrst_lo", 64'(lo_o), 64'd0);
        check("midrst_we", 64'(hilo_we), 64'd0);
        check("midrst_stall", 64'(stall_div), 64'd0);
        rst = 1'b1;

        // start together with annul in IDLE is dropped
        @(posedge clk);
        #1;
        startE = 1'b1; annulE = 1'b1; srcaE = 32'd9; srcbE = 32'd3;
        @(negedge clk);
        check("start_annul_stall", 64'(stall_div), 64'd0);
        @(posedge clk);
        #1;
        startE = 1'b0; annulE = 1'b0;
        @(negedge clk);
        check("start_annul_idle", 64'(stall_div), 64'd0);
        repeat (40) @(negedge clk);
        check("start_annul_no_we", {hi_o, lo_o}, 64'd0);

        for (int i = 0; i < 24; i++) begin
            a   = $urandom;
            sel = $urandom_range(0, 7);
            b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
                  (sel == 2) ? 32'($urandom_range(1, 15)) : $urandom;
            if (sel == 1 && (i % 2) == 1) a = 32'h8000_0000;
            f   = ($urandom_range(0, 1) == 1) ? DIV : DIVU;
            run_div(a, b, f);
        end

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for MIPS DIV/DIVU in the execute stage. It captures operands when a divide issues and runs a 32-iteration radix-2 restoring divide. While the divide runs, it holds the pipeline through a stall output. On completion it presents HI/LO with a one-cycle write strobe. A flush cancels an in-flight divide without touching HI/LO.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. Iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset: one clock; reset is synchronous and active-low (`rst`=0 resets on the next `clk` edge).
- `startE`  in  1  a DIV/DIVU instruction is in E this cycle.
- `signedE`  in  1  1 = DIV (signed), 0 = DIVU.
- `srcaE`  in  WIDTH  dividend (rs).
- `srcbE`  in  WIDTH  divisor (rt).
- `annulE`  in  1  flush/exception cancel for E; kills any divide.
- `stall_div`  out  1  stall request to hazard logic; combinational.
- `hi_o`  out  WIDTH  remainder; registered.
- `lo_o`  out  WIDTH  quotient; registered.
- `hilo_we`  out  1  one-cycle HI/LO write strobe; registered.

## Operation
- States are IDLE, BUSY and DONE. Reset puts the block in IDLE with `hi_o`=0, `lo_o`=0, `hilo_we`=0 and the iteration counter at 0.
- **IDLE, `startE`=1 and `annulE`=0:**
  - Capture `|srcaE|` and `|srcbE|`. Magnitudes are used only when `signedE`=1; otherwise the raw values are captured.
  - Latch the quotient-negate flag (sign a XOR sign b, signed only) and the remainder-negate flag (sign a, signed only).
  - Clear the partial remainder and the counter, then go to BUSY.
- **BUSY:** each cycle performs one restoring step.
  - Shift {rem, quo} left by 1.
  - Form trial = rem − divisor, computed at WIDTH+1 bits.
  - If trial ≥ 0: rem = trial and set the quotient LSB.
  - Increment the counter.
  - After the step with counter = WIDTH−1, go to DONE.
- **DONE:**
  - `lo_o` = quo, negated if the quotient flag is set.
  - `hi_o` = rem, negated if the remainder flag is set.
  - `hilo_we`=1 for exactly this cycle, then return to IDLE.
- `stall_div` = (IDLE & `startE` & !`annulE`) | BUSY. It is low in DONE, so the divide instruction leaves E in the same cycle HI/LO is written.
- Divide by zero has fixed behaviour and the full normal latency:
  - `lo_o` = all ones.
  - `hi_o` = dividend, sign-restored if signed.
- Signed overflow: 0x80000000 / −1 gives `lo_o`=0x80000000 and `hi_o`=0. Magnitude arithmetic must use the unsigned interpretation of 0x80000000.
- Boundary rules:
  - `annulE`=1 in any state: go to IDLE on the next edge. No `hilo_we` is issued and `hi_o`/`lo_o` are unchanged. `annulE` wins over a simultaneous `startE`.
  - `startE` in BUSY or DONE is ignored. The hazard stall keeps the same instruction in E.
  - `rst`=0 mid-operation: the next edge fully resets the block. No strobe is issued.

## Timing
- Cycle 0: `startE` is sampled in IDLE and `stall_div`=1 combinationally.
- Cycles 1..WIDTH: BUSY, with `stall_div`=1.
- Cycle WIDTH+1: DONE, with `hilo_we`=1 and valid `hi_o`/`lo_o`.
- Total latency is WIDTH+1 = 33 cycles from start to strobe, and the stall lasts 33 cycles.
- Minimum spacing is 34 cycles between accepted starts. A new divide may enter E the cycle after DONE.
- `hi_o` and `lo_o` hold their values until the next DONE.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10);
  - the funct constants DIV=6'b011010 and DIVU=6'b011011, which the decoder also uses to derive `startE`/`signedE`;
  - `DIV_ITER`=`WIDTH`.
- One sub-module, `div_step`: a combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
- The sequencer owns the FSM, counter, sign flags and output registers.

## Test plan
- DIVU 100/7, stall held the full window → `hilo_we` at cycle 33 with `lo_o`=14 and `hi_o`=2. `stall_div` is high for cycles 0..32.
- DIV −7/2 (0xFFFFFFF9 / 2) → `lo_o`=0xFFFFFFFD and `hi_o`=0xFFFFFFFF. Then DIV 7/−2 → `lo_o`=0xFFFFFFFD and `hi_o`=1.
- DIV 0x80000000 / 0xFFFFFFFF → `lo_o`=0x80000000 and `hi_o`=0. DIVU 0xFFFFFFFF/1 → `lo_o`=0xFFFFFFFF and `hi_o`=0.
- DIVU 1234/0 → `lo_o`=0xFFFFFFFF and `hi_o`=1234 at cycle 33.
- Complete 100/7, then start 50/5 and pulse `annulE` at cycle 10 → no strobe, `stall_div` low from cycle 11, `hi_o`/`lo_o` still 2/14. A restart of 50/5 then gives 0/10.
- `rst`=0 at cycle 20 of a divide → next cycle the block is in IDLE with all outputs 0. A `startE` asserted together with `annulE` in IDLE → no stall and the block stays in IDLE.
